mem_store_seq: RTL and testbench
================================

MEM_STORE_SEQ -- requirements
Module: mem_store_seq

Interface
REQ-001 The block SHALL have parameter BEAT_BYTES, default 8, meaning the address increment per beat.
REQ-002 The block SHALL have parameter MAX_BEATS, default 4, meaning the beat capacity of req_data_i.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-004 The block SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 The block SHALL have port req_valid_i, input, 1, store request present.
REQ-006 The block SHALL have port req_ready_o, output, 1, request accepted this cycle when high together with req_valid_i.
REQ-007 The block SHALL have port req_addr_i, input, `DATA_WIDTH, store base address.
REQ-008 The block SHALL have port req_beats_i, input, 2, beat-count code: 0=1 beat, 1=2 beats, 2=4 beats, 3=illegal.
REQ-009 The block SHALL have port req_data_i, input, MAX_BEATS*`DATA_WIDTH, store data; beat k occupies bits [k*`DATA_WIDTH +: `DATA_WIDTH].
REQ-010 The block SHALL have port flush_i, input, 1, abort of the current sequence.
REQ-011 The block SHALL have port mem_we_o, output, 1, write beat valid.
REQ-012 The block SHALL have port mem_addr_o, output, `DATA_WIDTH, beat address.
REQ-013 The block SHALL have port mem_wdata_o, output, `DATA_WIDTH, beat data.
REQ-014 The block SHALL have port mem_ready_i, input, 1, memory accepts the beat when high together with mem_we_o.
REQ-015 The block SHALL have port stall_o, output, 1, pipeline stall request.
REQ-016 The block SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-017 The block SHALL have port err_o, output, 1, one-cycle illegal-code pulse.

Function
REQ-018 The FSM SHALL have states IDLE and ISSUE.
REQ-019 req_ready_o SHALL equal (state==IDLE), combinationally.
REQ-020 On acceptance, base address, data, and last-beat index (0/1/3) SHALL be registered; beat index SHALL clear to 0; state SHALL go to ISSUE.
REQ-021 Code 3 SHALL be accepted and treated as 1 beat, and err_o SHALL pulse in the cycle after acceptance.
REQ-022 In ISSUE, mem_we_o SHALL equal !flush_i; mem_addr_o SHALL be base + idx*BEAT_BYTES modulo 2^`DATA_WIDTH (wrap, no error); mem_wdata_o SHALL be registered beat idx.
REQ-023 In IDLE, mem_we_o SHALL be 0 and mem_addr_o/mem_wdata_o SHALL be 0.
REQ-024 A beat SHALL complete on mem_we_o && mem_ready_i; idx SHALL increment on completion; with mem_ready_i low, all outputs SHALL hold.
REQ-025 On completion of the last beat, the FSM SHALL go to IDLE and done_o SHALL pulse in the following cycle.
REQ-026 First beat latency SHALL be 1 cycle after acceptance, with N beats taking at least N cycles in ISSUE.
REQ-027 stall_o SHALL equal (state==ISSUE) || (req_valid_i && state==IDLE).
REQ-028 flush_i in ISSUE SHALL return the FSM to IDLE next cycle with no beat counted and no done_o; flush_i SHALL win over simultaneous mem_ready_i.
REQ-029 flush_i in IDLE SHALL be ignored; a request in the same cycle SHALL still be accepted.
REQ-030 A new request SHALL NOT be accepted in the cycle that the last beat completes; the earliest acceptance SHALL be the next cycle, when in IDLE.

Reset
REQ-031 Asserting rst SHALL asynchronously force state=IDLE, idx=0, registered address/data=0, and done_o=err_o=0.
REQ-032 Reset mid-sequence SHALL drop remaining beats without a done_o pulse, and mem_we_o SHALL fall immediately.

Structure
REQ-033 Package mem_store_pkg SHALL hold the state enum, the beat-code enum, and the function code-to-last-index.
REQ-034 Sub-module mem_store_beat_cnt SHALL hold the beat index register, increment/clear, and last-beat compare.
REQ-035 `DATA_WIDTH SHALL come from common/defines.svh, and no other global definitions SHALL be added.

Verification
REQ-036 Single-beat scenario: addr=0x1000, code 0, mem_ready_i=1 -> one beat at 0x1000, done_o in cycle 3, stall_o high cycles 1-2.
REQ-037 Four-beat scenario: addr=0x2000, code 2, ready=1 -> beats 0x2000/0x2008/0x2010/0x2018 with data slices 0..3 in order, done_o once.
REQ-038 Backpressure scenario: code 1 with mem_ready_i low for 3 cycles on beat 0 -> addr/data held, beat 1 at +8 only after acceptance.
REQ-039 Flush and wrap scenario: code 2, flush_i on beat 2 with ready=1 -> 2 beats only, no done_o, IDLE next cycle; addr=0xFFFF_FFFF_FFFF_FFF8, code 1 -> second beat at 0x0.
REQ-040 Error and reset scenario: code 3 -> one beat and err_o pulse; rst asserted mid 4-beat sequence -> mem_we_o low asynchronously, no done_o, req_ready_o high after release.

Source files
------------

// File: rtl/mem_store_pkg.sv
// rtl/mem_store_pkg.sv - shared types and helpers for the store sequencer
`include "common/defines.svh"

package mem_store_pkg;

  // Sequencer states; one bit is enough for IDLE/ISSUE
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  // Beat-count request codes
  typedef enum logic [1:0] {
    BEATS_1   = 2'd0,
    BEATS_2   = 2'd1,
    BEATS_4   = 2'd2,
    BEATS_ILL = 2'd3
  } beat_code_e;

  localparam int IDX_W = 2;

  // Index of the final beat for a request code; the illegal code runs as one beat
  function automatic logic [IDX_W-1:0] code_to_last_idx(input beat_code_e code);
    logic [IDX_W-1:0] last;
    case (code)
      BEATS_1: last = 2'd0;
      BEATS_2: last = 2'd1;
      BEATS_4: last = 2'd3;
      default: last = 2'd0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/common/defines.svh
// rtl/common/defines.svh - global datapath width
`ifndef COMMON_DEFINES_SVH
`define COMMON_DEFINES_SVH
`define DATA_WIDTH 64
`endif

// File: rtl/mem_store_beat_cnt.sv
// rtl/mem_store_beat_cnt.sv - beat index register with clear, increment and last compare
import mem_store_pkg::*;

module mem_store_beat_cnt (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [IDX_W-1:0] last_idx_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o
);

  logic [IDX_W-1:0] idx_d, idx_q;

  // Clear takes priority so a fresh request always starts at beat 0
  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = idx_q + 1'b1;
    end
  end

  // Index register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == last_idx_i);

endmodule

// File: rtl/mem_store_seq.sv
// rtl/mem_store_seq.sv - multi-beat store sequencer issuing one write beat per accepted cycle
`include "common/defines.svh"
import mem_store_pkg::*;

module mem_store_seq #(
  parameter int BEAT_BYTES = 8,
  parameter int MAX_BEATS  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic [`DATA_WIDTH-1:0]           req_addr_i,
  input  logic [1:0]                       req_beats_i,
  input  logic [MAX_BEATS*`DATA_WIDTH-1:0] req_data_i,
  input  logic                             flush_i,
  output logic                             mem_we_o,
  output logic [`DATA_WIDTH-1:0]           mem_addr_o,
  output logic [`DATA_WIDTH-1:0]           mem_wdata_o,
  input  logic                             mem_ready_i,
  output logic                             stall_o,
  output logic                             done_o,
  output logic                             err_o
);

  state_e                           state_d, state_q;
  logic [`DATA_WIDTH-1:0]           base_d, base_q;
  logic [MAX_BEATS*`DATA_WIDTH-1:0] data_d, data_q;
  logic [IDX_W-1:0]                 last_d, last_q;
  logic                             done_d, done_q;
  logic                             err_d, err_q;

  logic             idx_clr, idx_inc, idx_last;
  logic [IDX_W-1:0] idx;

  mem_store_beat_cnt u_beat_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (idx_clr),
    .inc_i      (idx_inc),
    .last_idx_i (last_q),
    .idx_o      (idx),
    .last_o     (idx_last)
  );

  // Next-state: accept in IDLE, walk beats in ISSUE; flush beats a simultaneous ready
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    data_d  = data_q;
    last_d  = last_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    idx_clr = 1'b0;
    idx_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          state_d = ST_ISSUE;
          base_d  = req_addr_i;
          data_d  = req_data_i;
          last_d  = code_to_last_idx(beat_code_e'(req_beats_i));
          idx_clr = 1'b1;
          err_d   = (beat_code_e'(req_beats_i) == BEATS_ILL);
        end
      end
      ST_ISSUE: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (mem_ready_i) begin
          if (idx_last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state and captured request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      data_q  <= '0;
      last_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Beat outputs are decoded from state so reset drops the write strobe at once
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (state_q == ST_ISSUE) begin
      mem_we_o    = !flush_i;
      mem_addr_o  = base_q + (`DATA_WIDTH'(idx) * `DATA_WIDTH'(BEAT_BYTES));
      mem_wdata_o = data_q[32'(idx) * `DATA_WIDTH +: `DATA_WIDTH];
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign stall_o     = (state_q == ST_ISSUE) || (req_valid_i && (state_q == ST_IDLE));
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_store_seq.sv
// tb/tb_mem_store_seq.sv - directed self-checking bench for mem_store_seq
module tb_mem_store_seq;

  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [DW-1:0]   req_addr_i;
  logic [1:0]      req_beats_i;
  logic [4*DW-1:0] req_data_i;
  logic            flush_i;
  logic            mem_we_o;
  logic [DW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_wdata_o;
  logic            mem_ready_i;
  logic            stall_o;
  logic            done_o;
  logic            err_o;

  int n_checks = 0;
  int n_fails  = 0;

  logic [DW-1:0] w [4];

  mem_store_seq #(.BEAT_BYTES(8), .MAX_BEATS(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_beats_i (req_beats_i),
    .req_data_i  (req_data_i),
    .flush_i     (flush_i),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ready_i (mem_ready_i),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 2ns later
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_beats_i = 2'd0;
    req_data_i = '0; flush_i = 1'b0; mem_ready_i = 1'b1;
    repeat (2) step();
    #2;
    n_checks++; if (req_ready_o !== 1'b1) begin n_fails++; $display("FAIL reset_ready got=%b exp=1", req_ready_o); end
    n_checks++; if (mem_we_o !== 1'b0) begin n_fails++; $display("FAIL reset_we got=%b exp=0", mem_we_o); end
    n_checks++; if (mem_addr_o !== '0) begin n_fails++; $display("FAIL reset_addr got=%h exp=0", mem_addr_o); end
    n_checks++; if ({done_o, err_o, stall_o} !== 3'b000) begin n_fails++; $display("FAIL reset_flags got=%b exp=000", {done_o, err_o, stall_o}); end
    step(); rst = 1'b0;
  endtask

  task automatic test_single();
    step();
    req_valid_i = 1'b1; req_addr_i = 64'h1000; req_beats_i = 2'd0;
    req_data_i = {w[3], w[2], w[1], w[0]}; mem_ready_i = 1'b1;
    #2;
    n_checks++; if ({stall_o, req_ready_o, mem_we_o} !== 3'b110) begin n_fails++; $display("FAIL single_c1 stall/ready/we got=%b exp=110", {stall_o, req_ready_o, mem_we_o}); end
    step(); req_valid_i = 1'b0; #2;
    n_checks++; if ({mem_we_o, stall_o, done_o} !== 3'b110) begin n_fails++; $display("FAIL single_c2 we/stall/done got=%b exp=110", {mem_we_o, stall_o, done_o}); end
    n_checks++; if (mem_addr_o !== 64'h1000) begin n_fails++; $display("FAIL single_addr got=%h exp=1000", mem_addr_o); end
    n_checks++; if (mem_wdata_o !== w[0]) begin n_fails++; $display("FAIL single_data got=%h exp=%h", mem_wdata_o, w[0]); end
    step(); #2;
    n_checks++; if ({done_o, stall_o, mem_we_o, req_ready_o} !== 4'b1001) begin n_fails++; $display("FAIL single_c3 done/stall/we/ready got=%b exp=1001", {done_o, stall_o, mem_we_o, req_ready_o}); end
    step(); #2;
    n_checks++; if (done_o !== 1'b0) begin n_fails++; $display("FAIL single_done_pulse got=%b exp=0", done_o); end
  endtask

  task automatic test_four_beat();
    int dones;
    step();
    req_valid_i = 1'b1; req_addr_i = 64'h2000; req_beats_i = 2'd2;
    req_data_i = {w[3], w[2], w[1], w[0]}; mem_ready_i = 1'b1;
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      step(); req_valid_i = 1'b0; #2;
      n_checks++; if (mem_we_o !== 1'b1) begin n_fails++; $display("FAIL four_we[%0d] got=%b exp=1", k, mem_we_o); end
      n_checks++; if (mem_addr_o !== 64'h2000 + 64'(8 * k)) begin n_fails++; $display("FAIL four_addr[%0d] got=%h exp=%h", k, mem_addr_o, 64'h2000 + 64'(8 * k)); end
      n_checks++; if (mem_wdata_o !== w[k]) begin n_fails++; $display("FAIL four_data[%0d] got=%h exp=%h", k, mem_wdata_o, w[k]); end
      if (done_o) dones++;
    end
    for (int k = 0; k < 3; k++) begin
      step(); #2;
      if (done_o) dones++;
    end
    n_checks++; if (dones != 1) begin n_fails++; $display("FAIL four_done_count got=%0d exp=1", dones); end
  endtask

  task automatic test_backpressure();
    step();
    req_valid_i = 1'b1; req_addr_i = 64'h3000; req_beats_i = 2'd1;
    req_data_i = {w[3], w[2], w[1], w[0]}; mem_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); req_valid_i = 1'b0; #2;
      n_checks++; if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 64'h3000, w[0]}) begin n_fails++; $display("FAIL bp_hold[%0d] we=%b addr=%h data=%h exp 1/3000/%h", k, mem_we_o, mem_addr_o, mem_wdata_o, w[0]); end
    end
    step(); mem_ready_i = 1'b1; #2;
    n_checks++; if (mem_addr_o !== 64'h3000) begin n_fails++; $display("FAIL bp_accept_addr got=%h exp=3000", mem_addr_o); end
    step(); #2;
    n_checks++; if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 64'h3008, w[1]}) begin n_fails++; $display("FAIL bp_beat1 we=%b addr=%h data=%h exp 1/3008/%h", mem_we_o, mem_addr_o, mem_wdata_o, w[1]); end
    step(); #2;
    n_checks++; if (done_o !== 1'b1) begin n_fails++; $display("FAIL bp_done got=%b exp=1", done_o); end
  endtask

  task automatic test_flush_wrap();
    int dones;
    dones = 0;
    step();
    req_valid_i = 1'b1; req_addr_i = 64'h4000; req_beats_i = 2'd2; mem_ready_i = 1'b1;
    step(); req_valid_i = 1'b0; #2;
    n_checks++; if (mem_addr_o !== 64'h4000) begin n_fails++; $display("FAIL flush_b0 got=%h exp=4000", mem_addr_o); end
    step(); #2;
    n_checks++; if (mem_addr_o !== 64'h4008) begin n_fails++; $display("FAIL flush_b1 got=%h exp=4008", mem_addr_o); end
    step(); flush_i = 1'b1; #2;
    n_checks++; if (mem_we_o !== 1'b0) begin n_fails++; $display("FAIL flush_we got=%b exp=0", mem_we_o); end
    if (done_o) dones++;
    step(); flush_i = 1'b0; #2;
    if (done_o) dones++;
    n_checks++; if ({req_ready_o, mem_we_o} !== 2'b10) begin n_fails++; $display("FAIL flush_idle ready/we got=%b exp=10", {req_ready_o, mem_we_o}); end
    step(); #2;
    if (done_o) dones++;
    n_checks++; if (dones != 0) begin n_fails++; $display("FAIL flush_no_done got=%0d exp=0", dones); end
    // flush while idle must not block a request in the same cycle
    flush_i = 1'b1; req_valid_i = 1'b1; req_addr_i = 64'hFFFF_FFFF_FFFF_FFF8; req_beats_i = 2'd1;
    step(); flush_i = 1'b0; req_valid_i = 1'b0; #2;
    n_checks++; if ({mem_we_o, mem_addr_o} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFF8}) begin n_fails++; $display("FAIL wrap_b0 we=%b addr=%h exp 1/fffffffffffffff8", mem_we_o, mem_addr_o); end
    step(); #2;
    n_checks++; if ({mem_we_o, mem_addr_o} !== {1'b1, 64'h0}) begin n_fails++; $display("FAIL wrap_b1 we=%b addr=%h exp 1/0", mem_we_o, mem_addr_o); end
    step(); #2;
    n_checks++; if (done_o !== 1'b1) begin n_fails++; $display("FAIL wrap_done got=%b exp=1", done_o); end
  endtask

  task automatic test_err_reset();
    int dones;
    dones = 0;
    step();
    req_valid_i = 1'b1; req_addr_i = 64'h5000; req_beats_i = 2'd3; mem_ready_i = 1'b1;
    step(); req_valid_i = 1'b0; #2;
    n_checks++; if ({mem_we_o, err_o, mem_addr_o, mem_wdata_o} !== {1'b1, 1'b1, 64'h5000, w[0]}) begin n_fails++; $display("FAIL err_beat we=%b err=%b addr=%h data=%h", mem_we_o, err_o, mem_addr_o, mem_wdata_o); end
    step(); #2;
    n_checks++; if ({done_o, err_o, mem_we_o} !== 3'b100) begin n_fails++; $display("FAIL err_end done/err/we got=%b exp=100", {done_o, err_o, mem_we_o}); end
    // reset in the middle of a four-beat sequence
    step();
    req_valid_i = 1'b1; req_addr_i = 64'h6000; req_beats_i = 2'd2;
    step(); req_valid_i = 1'b0;
    step(); #2;
    n_checks++; if ({mem_we_o, mem_addr_o} !== {1'b1, 64'h6008}) begin n_fails++; $display("FAIL rst_pre we=%b addr=%h exp 1/6008", mem_we_o, mem_addr_o); end
    rst = 1'b1; #1;
    n_checks++; if ({mem_we_o, req_ready_o} !== 2'b01) begin n_fails++; $display("FAIL rst_async we/ready got=%b exp=01", {mem_we_o, req_ready_o}); end
    step(); rst = 1'b0; #2;
    if (done_o) dones++;
    for (int k = 0; k < 3; k++) begin
      step(); #2;
      if (done_o) dones++;
    end
    n_checks++; if ({req_ready_o, mem_we_o} !== 2'b10) begin n_fails++; $display("FAIL rst_release ready/we got=%b exp=10", {req_ready_o, mem_we_o}); end
    n_checks++; if (dones != 0) begin n_fails++; $display("FAIL rst_no_done got=%0d exp=0", dones); end
  endtask

  task automatic test_back_to_back();
    step();
    req_valid_i = 1'b1; req_addr_i = 64'h7000; req_beats_i = 2'd0; mem_ready_i = 1'b1;
    step(); #2;
    n_checks++; if ({req_ready_o, mem_we_o, stall_o} !== 3'b011) begin n_fails++; $display("FAIL b2b_busy ready/we/stall got=%b exp=011", {req_ready_o, mem_we_o, stall_o}); end
    step(); #2;
    n_checks++; if ({req_ready_o, done_o, mem_we_o} !== 3'b110) begin n_fails++; $display("FAIL b2b_reaccept ready/done/we got=%b exp=110", {req_ready_o, done_o, mem_we_o}); end
    step(); req_valid_i = 1'b0; #2;
    n_checks++; if ({mem_we_o, mem_addr_o} !== {1'b1, 64'h7000}) begin n_fails++; $display("FAIL b2b_second we=%b addr=%h exp 1/7000", mem_we_o, mem_addr_o); end
    step(); #2;
    n_checks++; if (done_o !== 1'b1) begin n_fails++; $display("FAIL b2b_done got=%b exp=1", done_o); end
  endtask

  initial begin
    w[0] = 64'h0101_0101_A0A0_0000;
    w[1] = 64'h0202_0202_B1B1_1111;
    w[2] = 64'h0303_0303_C2C2_2222;
    w[3] = 64'h0404_0404_D3D3_3333;
    test_reset();
    test_single();
    test_four_beat();
    test_backpressure();
    test_flush_wrap();
    test_err_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
